rcpu_mem_responder: RTL and testbench

RCPU_MEM_RESPONDER -- requirements
Module: rcpu_mem_responder

---
 rtl/rcpu_mem_pkg.sv | 35 +++
 rtl/rcpu_sp_ram.sv | 23 ++
 rtl/rcpu_mem_responder.sv | 139 +++++++++++++
 tb/tb_rcpu_mem_responder.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/rcpu_mem_pkg.sv
// Shared constants, FSM encoding and address decode for the RCPU memory responder.
package rcpu_mem_pkg;

  localparam logic [31:0] MAIN_BASE     = 32'h0000_0000;
  localparam logic [31:0] STACK_BASE    = 32'hD000_0000;
  localparam logic [31:0] PAGE_ADDR     = 32'hFFFF_0000;
  localparam logic [15:0] UNMAPPED_DATA = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_READY = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    RG_MAIN  = 2'd0,
    RG_STACK = 2'd1,
    RG_PAGE  = 2'd2,
    RG_NONE  = 2'd3
  } region_t;

  // Regions are aligned to their own size, so a shifted compare of the base is enough.
  function automatic region_t decode_region(input logic [31:0] addr, input int aw, input int sw);
    region_t rg;
    rg = RG_NONE;
    if ((addr >> aw) == (MAIN_BASE >> aw))
      rg = RG_MAIN;
    else if ((addr >> sw) == (STACK_BASE >> sw))
      rg = RG_STACK;
    else if (addr == PAGE_ADDR)
      rg = RG_PAGE;
    return rg;
  endfunction

endpackage

// File: rtl/rcpu_sp_ram.sv
// Single-port synchronous RAM; a write takes the port, otherwise a read registers the addressed word.
module rcpu_sp_ram #(
  parameter int AW     = 10,
  parameter int DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [AW-1:0]     i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**AW];

  always_ff @(posedge i_clk) begin
    if (i_we)
      r_mem[i_addr] <= i_wdata;
    else if (i_re)
      o_rdata <= r_mem[i_addr];
  end

endmodule

// File: rtl/rcpu_mem_responder.sv
// Memory responder for the RCPU bus: main RAM, stack RAM and a page register
// behind a read FSM with a programmable number of wait cycles.
module rcpu_mem_responder
  import rcpu_mem_pkg::*;
#(
  parameter int AW   = 10,
  parameter int SW   = 8,
  parameter int WAIT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] memAddr,
  input  logic [15:0] memWrite,
  input  logic        memRE,
  input  logic        memWE,
  output logic        memReady,
  output logic [15:0] memRead,
  output logic [15:0] page,
  output logic        busError
);

  localparam logic [3:0] WAIT_CNT = 4'(WAIT);

  rd_state_t   r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [15:0] r_page;
  logic        r_bus_err;
  logic [31:0] r_addr;
  region_t     r_region;

  region_t     w_cur_region;
  logic        w_we_main, w_we_stack, w_we_page, w_we_none;
  logic        w_conflict, w_latch, w_rd_fire;
  logic [15:0] w_main_rdata, w_stack_rdata;

  assign w_cur_region = decode_region(memAddr, AW, SW);
  assign w_we_main    = memWE && (w_cur_region == RG_MAIN);
  assign w_we_stack   = memWE && (w_cur_region == RG_STACK);
  assign w_we_page    = memWE && (w_cur_region == RG_PAGE);
  assign w_we_none    = memWE && (w_cur_region == RG_NONE);

  // A write holding the port of the RAM being read delays the sample by a cycle.
  assign w_conflict = (w_we_main && (r_region == RG_MAIN)) ||
                      (w_we_stack && (r_region == RG_STACK));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_latch     = 1'b0;
    w_rd_fire   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (memRE) begin
          w_state_nxt = ST_BUSY;
          w_cnt_nxt   = WAIT_CNT;
          w_latch     = 1'b1;
        end
      end
      ST_BUSY: begin
        if (!memRE) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (memAddr != r_addr) begin
          w_cnt_nxt = WAIT_CNT;
          w_latch   = 1'b1;
        end else if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else if (!w_conflict) begin
          w_rd_fire   = 1'b1;
          w_state_nxt = ST_READY;
        end
      end
      ST_READY: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_page    <= '0;
      r_bus_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bus_err <= w_we_none || (w_rd_fire && (r_region == RG_NONE));
      if (w_we_page)
        r_page <= memWrite;
    end
  end

  always_ff @(posedge clk) begin
    if (w_latch) begin
      r_addr   <= memAddr;
      r_region <= w_cur_region;
    end
  end

  rcpu_sp_ram #(.AW(AW), .DATA_W(16)) u_main_ram (
    .i_clk   (clk),
    .i_we    (w_we_main),
    .i_re    (w_rd_fire && (r_region == RG_MAIN)),
    .i_addr  (w_we_main ? memAddr[AW-1:0] : r_addr[AW-1:0]),
    .i_wdata (memWrite),
    .o_rdata (w_main_rdata)
  );

  rcpu_sp_ram #(.AW(SW), .DATA_W(16)) u_stack_ram (
    .i_clk   (clk),
    .i_we    (w_we_stack),
    .i_re    (w_rd_fire && (r_region == RG_STACK)),
    .i_addr  (w_we_stack ? memAddr[SW-1:0] : r_addr[SW-1:0]),
    .i_wdata (memWrite),
    .o_rdata (w_stack_rdata)
  );

  always_comb begin
    memRead = '0;
    if (r_state == ST_READY) begin
      case (r_region)
        RG_MAIN:  memRead = w_main_rdata;
        RG_STACK: memRead = w_stack_rdata;
        RG_PAGE:  memRead = r_page;
        default:  memRead = UNMAPPED_DATA;
      endcase
    end
  end

  assign memReady = !memRE || (r_state == ST_READY);
  assign page     = r_page;
  assign busError = r_bus_err;

endmodule

// File: tb/tb_rcpu_mem_responder.sv
// Scoreboard bench for rcpu_mem_responder: reads push expected data, a negedge monitor checks completions.
module tb_rcpu_mem_responder;

  localparam int WAIT_P = 2;
  localparam int LAT    = WAIT_P + 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] memAddr;
  logic [15:0] memWrite;
  logic        memRE, memWE;
  logic        memReady;
  logic [15:0] memRead, page;
  logic        busError;

  int n_checks = 0;
  int n_pass   = 0;
  logic [16:0] sb [$];   // {busError, data}

  rcpu_mem_responder #(.AW(10), .SW(8), .WAIT(WAIT_P)) dut (
    .clk      (clk),
    .rst      (rst),
    .memAddr  (memAddr),
    .memWrite (memWrite),
    .memRE    (memRE),
    .memWE    (memWE),
    .memReady (memReady),
    .memRead  (memRead),
    .page     (page),
    .busError (busError)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: a read completes when memRE && memReady.
  always @(negedge clk) begin
    if (!rst && memRE && memReady) begin
      if (sb.size() == 0) begin
        check("unexpected_completion", {15'd0, busError, memRead}, 32'h1DEAD);
      end else begin
        logic [16:0] e;
        e = sb.pop_front();
        check("rd_data", {16'd0, memRead}, {16'd0, e[15:0]});
        check("rd_buserr", {31'd0, busError}, {31'd0, e[16]});
      end
    end
  end

  task automatic do_write(input logic [31:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    memAddr = a; memWrite = d; memWE = 1'b1; memRE = 1'b0;
    @(posedge clk); #1;
    memWE = 1'b0;
  endtask

  // Read; optional same-cycle write, optional address change after chg_at low cycles.
  task automatic do_read(input logic [31:0] a, input logic [15:0] exp_d, input logic exp_e,
                         input int exp_lat, input logic wr, input logic [15:0] wd,
                         input int chg_at, input logic [31:0] chg_addr, input string name);
    int  lat;
    bit  done;
    sb.push_back({exp_e, exp_d});
    @(posedge clk); #1;
    memAddr = a; memRE = 1'b1; memWE = wr; memWrite = wd;
    lat = 0; done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (memReady) done = 1;
      else begin
        lat++;
        @(posedge clk); #1;
        memWE = 1'b0;
        if (lat == chg_at) memAddr = chg_addr;
      end
    end
    if (!done) begin
      check({name, "_timeout"}, 32'd0, 32'd1);
      void'(sb.pop_back());
      memRE = 1'b0;
    end else begin
      check({name, "_latency"}, lat, exp_lat);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; memAddr = '0; memWrite = '0; memRE = 1'b0; memWE = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ready",   {31'd0, memReady}, 32'd1);
    check("rst_read",    {16'd0, memRead},  32'd0);
    check("rst_page",    {16'd0, page},     32'd0);
    check("rst_buserr",  {31'd0, busError}, 32'd0);

    // Main RAM write then read with WAIT wait cycles.
    do_write(32'h0000_0005, 16'h1234);
    do_read(32'h0000_0005, 16'h1234, 1'b0, LAT, 1'b0, 16'h0, -1, 32'h0, "rd_main5");

    // Stack and main RAM are separate arrays; back-to-back reads.
    do_write(32'hD000_0010, 16'hBEEF);
    do_write(32'h0000_0010, 16'h0010);
    do_read(32'hD000_0010, 16'hBEEF, 1'b0, LAT, 1'b0, 16'h0, -1, 32'h0, "rd_stack");
    do_read(32'h0000_0010, 16'h0010, 1'b0, LAT, 1'b0, 16'h0, -1, 32'h0, "rd_main10");

    // Page register.
    do_write(32'hFFFF_0000, 16'h00A5);
    @(negedge clk);
    check("page_upd",    {16'd0, page},     32'h00A5);
    check("page_noerr",  {31'd0, busError}, 32'd0);
    do_read(32'hFFFF_0000, 16'h00A5, 1'b0, LAT, 1'b0, 16'h0, -1, 32'h0, "rd_page");

    // Unmapped write: pulse only, RAM untouched.
    do_write(32'h0000_0000, 16'h1111);
    do_write(32'h8000_0000, 16'h7777);
    @(negedge clk);
    check("wr_unmap_err", {31'd0, busError}, 32'd1);
    @(negedge clk);
    check("wr_unmap_pulse_end", {31'd0, busError}, 32'd0);
    do_read(32'h8000_0000, 16'hFFFF, 1'b1, LAT, 1'b0, 16'h0, -1, 32'h0, "rd_unmap");
    do_read(32'h0000_0000, 16'h1111, 1'b0, LAT, 1'b0, 16'h0, -1, 32'h0, "rd_main0");

    // Write and read the same address in the same cycle.
    do_read(32'h0000_0020, 16'h5A5A, 1'b0, LAT, 1'b1, 16'h5A5A, -1, 32'h0, "rd_wr_same");

    // Address change mid-BUSY restarts the wait.
    do_write(32'h0000_0006, 16'h6666);
    do_read(32'h0000_0005, 16'h6666, 1'b0, 2 + LAT, 1'b0, 16'h0, 2, 32'h0000_0006, "rd_restart");

    // Abort by dropping memRE in BUSY.
    @(posedge clk); #1;
    memAddr = 32'h0000_0005; memRE = 1'b1; memWE = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    memRE = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_ready",  {31'd0, memReady}, 32'd1);
      check("abort_noerr",  {31'd0, busError}, 32'd0);
    end

    // Reset in the middle of a read.
    @(posedge clk); #1;
    memAddr = 32'h0000_0006; memRE = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; memRE = 1'b0;
    @(negedge clk);
    check("midrst_ready",  {31'd0, memReady}, 32'd1);
    check("midrst_page",   {16'd0, page},     32'd0);
    check("midrst_buserr", {31'd0, busError}, 32'd0);
    check("midrst_read",   {16'd0, memRead},  32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("postrst_ready", {31'd0, memReady}, 32'd1);
    do_read(32'h0000_0005, 16'h1234, 1'b0, LAT, 1'b0, 16'h0, -1, 32'h0, "rd_after_rst");

    @(posedge clk); #1;
    memRE = 1'b0;
    repeat (3) @(posedge clk);
    check("sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
